// File: rtl/mkio_msg_buffer.sv
// mkio_msg_buffer: per-channel ping-pong message store for MKIO subaddress data.
// Define MKIO_MSG_BUF_OVERWRITE_EN to let a new commit replace an unread message.
module mkio_msg_buffer #(
    parameter  int DATA_WIDTH = 16,
    parameter  int WORDS      = 32,
    parameter  int CHANNELS   = 4,
    localparam int CH_W       = $clog2(CHANNELS),
    localparam int PTR_W      = $clog2(WORDS),
    localparam int CNT_W      = $clog2(WORDS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic                  wr_start,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_commit,
    input  logic                  wr_abort,
    output logic                  wr_reject,
    output logic                  wr_overflow,
    input  logic [CH_W-1:0]       rd_ch,
    input  logic                  rd_start,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic [CNT_W-1:0]      rd_count,
    output logic [CHANNELS-1:0]   msg_ready
);

    localparam int DEPTH = 2 * CHANNELS * WORDS;
    localparam int AW    = $clog2(DEPTH);

`ifdef MKIO_MSG_BUF_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic {R_IDLE, R_READ} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0]      cnt [CHANNELS];
    logic [CHANNELS-1:0]   front;

    logic [CH_W-1:0]  w_ch;
    logic [CNT_W-1:0] w_ptr;
    logic [CH_W-1:0]  r_ch;
    logic [PTR_W-1:0] r_ptr;

    // At most one swap can wait for a reader: only the channel being read can be pending.
    logic             pend_valid;
    logic             pend_go;
    logic [CH_W-1:0]  pend_ch;
    logic [CNT_W-1:0] pend_cnt;

    logic w_open, w_we, w_rej, w_ovf, w_swap, w_pend;
    logic r_open, r_fire, r_done;
    logic rd_busy, ready_eff, start_blocked;

    function automatic logic [AW-1:0] addr(input logic [CH_W-1:0]  ch,
                                           input logic             bank,
                                           input logic [PTR_W-1:0] ptr);
        return AW'({ch, bank}) * AW'(WORDS) + AW'(ptr);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        r_open = 1'b0;
        r_fire = 1'b0;
        r_done = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (rd_start && msg_ready[rd_ch]) begin
                    r_next = R_READ;
                    r_open = 1'b1;
                end
            end
            R_READ: begin
                if (rd_req) begin
                    r_fire = 1'b1;
                    if (CNT_W'(r_ptr) + CNT_W'(1) == rd_count) begin
                        r_done = 1'b1;
                        r_next = R_IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    // A read finishing this cycle no longer holds the front bank.
    always_comb begin
        rd_busy = ((r_state == R_READ) && (r_ch == w_ch) && !r_done)
               || ((r_state == R_IDLE) && rd_start && (rd_ch == w_ch)
                   && msg_ready[w_ch]);
        ready_eff     = msg_ready[w_ch] && !(r_done && (r_ch == w_ch));
        start_blocked = pend_valid && (pend_ch == wr_ch);
    end

    always_comb begin
        w_next = w_state;
        w_open = 1'b0;
        w_we   = 1'b0;
        w_rej  = 1'b0;
        w_ovf  = 1'b0;
        w_swap = 1'b0;
        w_pend = 1'b0;
        if (wr_abort) begin
            w_next = W_IDLE;
        end else if (wr_commit) begin
            w_next = W_IDLE;
            if ((w_state == W_FILL) && (w_ptr != '0)) begin
                if (rd_busy)
                    w_pend = 1'b1;
                else if (ready_eff && !OVERWRITE)
                    w_rej = 1'b1;
                else
                    w_swap = 1'b1;
            end
        end else if (wr_start) begin
            if (start_blocked) begin
                w_rej = 1'b1;
            end else begin
                w_next = W_FILL;
                w_open = 1'b1;
            end
        end else if (wr_valid && (w_state == W_FILL)) begin
            if (w_ptr == CNT_W'(WORDS))
                w_ovf = 1'b1;
            else
                w_we = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_ch        <= '0;
            w_ptr       <= '0;
            wr_reject   <= 1'b0;
            wr_overflow <= 1'b0;
        end else begin
            wr_reject   <= w_rej;
            wr_overflow <= w_ovf;
            if (w_open) begin
                w_ch  <= wr_ch;
                w_ptr <= '0;
            end else if (w_we) begin
                w_ptr <= w_ptr + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_we)
            mem[addr(w_ch, ~front[w_ch], w_ptr[PTR_W-1:0])] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ch     <= '0;
            r_ptr    <= '0;
            rd_count <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= r_fire;
            rd_last  <= r_done;
            if (r_open) begin
                r_ch     <= rd_ch;
                r_ptr    <= '0;
                rd_count <= cnt[rd_ch];
            end
            if (r_fire) begin
                rd_data <= mem[addr(r_ch, front[r_ch], r_ptr)];
                if (!r_done)
                    r_ptr <= r_ptr + PTR_W'(1);
            end
        end
    end

    // Later assignments win: a direct swap re-arms a channel its reader just released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            front      <= '0;
            msg_ready  <= '0;
            pend_valid <= 1'b0;
            pend_go    <= 1'b0;
            pend_ch    <= '0;
            pend_cnt   <= '0;
            for (int i = 0; i < CHANNELS; i++)
                cnt[i] <= '0;
        end else begin
            if (r_done) begin
                msg_ready[r_ch] <= 1'b0;
                if (pend_valid && (pend_ch == r_ch))
                    pend_go <= 1'b1;
            end
            if (pend_go) begin
                front[pend_ch]     <= ~front[pend_ch];
                cnt[pend_ch]       <= pend_cnt;
                msg_ready[pend_ch] <= 1'b1;
                pend_valid         <= 1'b0;
                pend_go            <= 1'b0;
            end
            if (w_pend) begin
                pend_valid <= 1'b1;
                pend_ch    <= w_ch;
                pend_cnt   <= w_ptr;
            end
            if (w_swap) begin
                front[w_ch]     <= ~front[w_ch];
                cnt[w_ch]       <= w_ptr;
                msg_ready[w_ch] <= 1'b1;
            end
        end
    end

endmodule
